// File: rtl/vx_barrier_sched_pkg.sv
// vx_barrier_sched_pkg: shared barrier request/release bundles
// and width helpers for the per-core barrier scheduler.
`ifndef VX_BAR_WIDTH_MACROS
`define VX_BAR_WIDTH_MACROS
`define NW_WIDTH(n) (((n) > 1) ? $clog2(n) : 1)
`define NB_WIDTH(n) (((n) > 1) ? $clog2(n) : 1)
`endif

package vx_barrier_sched_pkg;

  localparam int BAR_NUM_WARPS    = 4;
  localparam int BAR_NUM_BARRIERS = 4;
  localparam int BAR_NW_W = `NW_WIDTH(BAR_NUM_WARPS);
  localparam int BAR_NB_W = `NB_WIDTH(BAR_NUM_BARRIERS);

  typedef struct packed {
    logic [BAR_NW_W-1:0] wid;
    logic [BAR_NB_W-1:0] id;
    logic [BAR_NW_W-1:0] size_m1;
  } bar_req_t;

  typedef struct packed {
    logic                     valid;
    logic [BAR_NB_W-1:0]      id;
    logic [BAR_NUM_WARPS-1:0] wmask;
  } bar_rel_t;

endpackage

// File: rtl/vx_barrier_sched_entry.sv
// vx_barrier_entry: one barrier table slot (wait mask, count, active)
// with arrive/flush strobes and same-cycle release/duplicate detection.
import vx_barrier_sched_pkg::*;

module vx_barrier_entry #(
  parameter int NUM_WARPS = 4,
  parameter int NW_W      = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 arrive,
  input  logic [NW_W-1:0]      wid,
  input  logic [NW_W-1:0]      size_m1,
  input  logic                 flush,
  input  logic [NW_W-1:0]      flush_wid,
  output logic [NUM_WARPS-1:0] wait_mask,
  output logic [NUM_WARPS-1:0] wait_mask_next,
  output logic                 hit_release,
  output logic                 dup
);

  logic                 active_q, active_d;
  logic [NW_W-1:0]      count_q, count_d;
  logic [NUM_WARPS-1:0] mask_q, mask_d;
  logic [NUM_WARPS-1:0] arr_bit, fl_bit;

  assign wait_mask      = mask_q;
  assign wait_mask_next = mask_d;

  always_comb begin
    arr_bit     = NUM_WARPS'(1) << wid;
    fl_bit      = NUM_WARPS'(1) << flush_wid;
    dup         = arrive && active_q && |(mask_q & arr_bit);
    hit_release = arrive && !dup &&
                  (active_q ? (count_q + NW_W'(1)) == size_m1
                            : size_m1 == '0);
    active_d = active_q;
    mask_d   = mask_q;
    count_d  = count_q;
    if (flush) begin
      if (active_q && |(mask_q & fl_bit)) begin
        mask_d  = mask_q & ~fl_bit;
        count_d = count_q - NW_W'(1);
        if (mask_d == '0) begin
          active_d = 1'b0;
          count_d  = '0;
        end
      end
    end else if (arrive && !dup) begin
      if (hit_release) begin
        active_d = 1'b0;
        mask_d   = '0;
        count_d  = '0;
      end else if (!active_q) begin
        active_d = 1'b1;
        mask_d   = arr_bit;
        count_d  = '0;
      end else begin
        mask_d  = mask_q | arr_bit;
        count_d = count_q + NW_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_q <= 1'b0;
      mask_q   <= '0;
      count_q  <= '0;
    end else begin
      active_q <= active_d;
      mask_q   <= mask_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/vx_barrier_sched.sv
// vx_barrier_sched: per-core barrier table, arrival decode,
// registered release pulse, duplicate flag and stalled-warp mask.
import vx_barrier_sched_pkg::*;

module vx_barrier_sched #(
  parameter int CORE_ID      = 0,
  parameter int NUM_WARPS    = BAR_NUM_WARPS,
  parameter int NUM_BARRIERS = BAR_NUM_BARRIERS,
  localparam int NW_W = `NW_WIDTH(NUM_WARPS),
  localparam int NB_W = `NB_WIDTH(NUM_BARRIERS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [NW_W-1:0]      req_wid,
  input  logic [NB_W-1:0]      req_id,
  input  logic [NW_W-1:0]      req_size_m1,
  input  logic                 flush_valid,
  input  logic [NW_W-1:0]      flush_wid,
  output logic                 rel_valid,
  output logic [NB_W-1:0]      rel_id,
  output logic [NUM_WARPS-1:0] rel_wmask,
  output logic [NUM_WARPS-1:0] stall_mask,
  output logic                 err_dup
);

  bar_req_t req;
  bar_rel_t rel_d, rel_q;
  logic     accept;
  logic     err_dup_d, err_dup_q;

  logic [NUM_WARPS-1:0]    stall_d, stall_q;
  logic [NUM_BARRIERS-1:0] arrive, hit, dup;
  logic [NUM_WARPS-1:0]    mask_q [NUM_BARRIERS];
  logic [NUM_WARPS-1:0]    mask_d [NUM_BARRIERS];

  assign req       = '{wid: req_wid, id: req_id, size_m1: req_size_m1};
  assign req_ready = reset & ~flush_valid;
  assign accept    = req_valid & req_ready;

  for (genvar i = 0; i < NUM_BARRIERS; i++) begin : g_ent
    assign arrive[i] = accept && (req.id == NB_W'(i));

    vx_barrier_entry #(
      .NUM_WARPS (NUM_WARPS),
      .NW_W      (NW_W)
    ) u_ent (
      .clk            (clk),
      .reset          (reset),
      .arrive         (arrive[i]),
      .wid            (req.wid),
      .size_m1        (req.size_m1),
      .flush          (flush_valid),
      .flush_wid      (flush_wid),
      .wait_mask      (mask_q[i]),
      .wait_mask_next (mask_d[i]),
      .hit_release    (hit[i]),
      .dup            (dup[i])
    );
  end

  always_comb begin
    rel_d     = '0;
    stall_d   = '0;
    err_dup_d = |dup;
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      stall_d = stall_d | mask_d[b];
      if (hit[b]) begin
        rel_d.valid = 1'b1;
        rel_d.id    = req.id;
        rel_d.wmask = mask_q[b] | (NUM_WARPS'(1) << req.wid);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rel_q     <= '0;
      stall_q   <= '0;
      err_dup_q <= 1'b0;
    end else begin
      rel_q     <= rel_d;
      stall_q   <= stall_d;
      err_dup_q <= err_dup_d;
    end
  end

  assign rel_valid  = rel_q.valid;
  assign rel_id     = rel_q.id;
  assign rel_wmask  = rel_q.wmask;
  assign stall_mask = stall_q;
  assign err_dup    = err_dup_q;

  // A warp parked on one barrier must not arrive at another.
  a_cross_bar: assert property (@(posedge clk) disable iff (!reset)
    accept |-> !(stall_q[req.wid] && !mask_q[req.id][req.wid]))
    else $error("vx_barrier_sched[%0d]: cross-barrier arrival", CORE_ID);

endmodule

// File: tb/tb_vx_barrier_sched.sv
// tb_vx_barrier_sched: directed stimulus, set-based barrier model
// compared every cycle, plus literal spot checks.
module tb_vx_barrier_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready;
  logic [1:0] req_wid, req_id, req_size_m1;
  logic       flush_valid;
  logic [1:0] flush_wid;
  logic       rel_valid;
  logic [1:0] rel_id;
  logic [3:0] rel_wmask, stall_mask;
  logic       err_dup;

  int n_chk  = 0;
  int n_fail = 0;

  bit [3:0] mm [4];
  bit       e_rv, e_dup;
  bit [1:0] e_rid;
  bit [3:0] e_wm, e_stall;

  always #5 clk = ~clk;

  vx_barrier_sched #(
    .CORE_ID      (0),
    .NUM_WARPS    (4),
    .NUM_BARRIERS (4)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_wid     (req_wid),
    .req_id      (req_id),
    .req_size_m1 (req_size_m1),
    .flush_valid (flush_valid),
    .flush_wid   (flush_wid),
    .rel_valid   (rel_valid),
    .rel_id      (rel_id),
    .rel_wmask   (rel_wmask),
    .stall_mask  (stall_mask),
    .err_dup     (err_dup)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each barrier is the set of warps waiting on it; a release
  // happens when the arrivals seen reach size_m1 + 1 participants.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 4; b++) mm[b] = '0;
      e_rv = 0; e_dup = 0; e_rid = 0; e_wm = 0;
    end else begin
      e_rv = 0; e_dup = 0; e_rid = 0; e_wm = 0;
      if (flush_valid) begin
        for (int b = 0; b < 4; b++) mm[b][flush_wid] = 1'b0;
      end else if (req_valid) begin
        if (mm[req_id][req_wid]) begin
          e_dup = 1;
        end else if ($countones(mm[req_id]) + 1 ==
                     int'(req_size_m1) + 1) begin
          e_rv  = 1;
          e_rid = req_id;
          e_wm  = mm[req_id] | (4'b0001 << req_wid);
          mm[req_id] = '0;
        end else begin
          mm[req_id][req_wid] = 1'b1;
        end
      end
    end
    e_stall = mm[0] | mm[1] | mm[2] | mm[3];
    #1;
    chk("rel_valid", rel_valid, e_rv);
    chk("rel_id", rel_id, e_rv ? e_rid : 2'd0);
    chk("rel_wmask", rel_wmask, e_wm);
    chk("stall_mask", stall_mask, e_stall);
    chk("err_dup", err_dup, e_dup);
    chk("req_ready", req_ready, rst_n && !flush_valid);
  end

  task automatic step(input bit v, input int w, input int id,
                      input int sz, input bit fv, input int fw);
    req_valid   = v;
    req_wid     = 2'(w);
    req_id      = 2'(id);
    req_size_m1 = 2'(sz);
    flush_valid = fv;
    flush_wid   = 2'(fw);
    @(posedge clk);
    #2;
  endtask

  task automatic arr(input int w, input int id, input int sz);
    step(1, w, id, sz, 0, 0);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    req_valid = 0; req_wid = 0; req_id = 0; req_size_m1 = 0;
    flush_valid = 0; flush_wid = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ready", req_ready, 0);
    chk("rst_stall", stall_mask, 0);
    rst_n = 1;

    arr(0, 1, 3); chk("t1_stall0", stall_mask, 4'b0001);
    arr(1, 1, 3); chk("t1_stall1", stall_mask, 4'b0011);
    arr(2, 1, 3); chk("t1_stall2", stall_mask, 4'b0111);
    arr(3, 1, 3);
    chk("t1_rv", rel_valid, 1);
    chk("t1_rid", rel_id, 1);
    chk("t1_wm", rel_wmask, 4'b1111);
    chk("t1_stall3", stall_mask, 4'b0000);
    idle(); chk("t1_pulse", rel_valid, 0);

    arr(2, 0, 0);
    chk("t2_rv", rel_valid, 1);
    chk("t2_wm", rel_wmask, 4'b0100);
    chk("t2_stall", stall_mask, 4'b0000);
    idle();

    arr(1, 2, 1);
    arr(1, 2, 1);
    chk("t3_dup", err_dup, 1);
    chk("t3_norel", rel_valid, 0);
    chk("t3_stall", stall_mask, 4'b0010);
    idle(); chk("t3_dup_pulse", err_dup, 0);
    arr(3, 2, 1);
    chk("t3_wm", rel_wmask, 4'b1010);
    idle();

    arr(0, 3, 2);
    arr(1, 3, 2);
    req_valid = 1; req_wid = 2; req_id = 3; req_size_m1 = 2;
    flush_valid = 1; flush_wid = 0;
    #1; chk("t4_ready", req_ready, 0);
    @(posedge clk); #2;
    chk("t4_stall", stall_mask, 4'b0010);
    chk("t4_norel", rel_valid, 0);
    arr(0, 3, 2); chk("t4_norel2", rel_valid, 0);
    arr(2, 3, 2);
    chk("t4_wm", rel_wmask, 4'b0111);
    idle();

    arr(0, 0, 1);
    arr(1, 1, 1);
    arr(2, 0, 1);
    chk("t5_rid0", rel_id, 0);
    chk("t5_wm0", rel_wmask, 4'b0101);
    arr(3, 1, 1);
    chk("t5_rv1", rel_valid, 1);
    chk("t5_rid1", rel_id, 1);
    chk("t5_wm1", rel_wmask, 4'b1010);
    idle();

    arr(0, 1, 3);
    arr(1, 1, 3);
    chk("t6_stall", stall_mask, 4'b0011);
    idle();
    rst_n = 0;
    #1;
    chk("t6_async_stall", stall_mask, 0);
    chk("t6_async_rv", rel_valid, 0);
    chk("t6_async_ready", req_ready, 0);
    @(posedge clk); #2;
    rst_n = 1;
    arr(0, 1, 1);
    chk("t6_norel", rel_valid, 0);
    chk("t6_stall2", stall_mask, 4'b0001);
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
